// File: rtl/mux2_gate_cell.sv
// One-bit 2:1 mux built from discrete gates (NOT, two AND, OR).
// Kept structural so each bit maps to the same small cell.
module mux2_gate_cell (
   input  logic a,
   input  logic b,
   input  logic s,
   output logic y
);

   logic s_n;
   logic a_term;
   logic b_term;

   assign s_n    = ~s;
   assign a_term = a & s_n;
   assign b_term = b & s;
   assign y      = a_term | b_term;

endmodule

// File: rtl/mux_2to1_gl.sv
// Parameterised gate-level 2:1 mux, y = s ? b : a, with an optional
// output register and valid flag for use on a clocked pipeline path.
module mux_2to1_gl #(
   parameter int WIDTH      = 1,
   parameter bit REGISTERED = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   input  logic             in_valid,
   output logic [WIDTH-1:0] y_comb,
   output logic [WIDTH-1:0] y,
   output logic             out_valid
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      mux2_gate_cell u_cell (
         .a (a[i]),
         .b (b[i]),
         .s (s),
         .y (y_comb[i])
      );
   end

   if (REGISTERED) begin : g_reg
      // y only loads on valid edges; out_valid marks whether it is fresh.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            y         <= '0;
            out_valid <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) begin
               y <= y_comb;
            end
         end
      end
   end else begin : g_comb
      logic unused_clk_rst;

      assign y              = y_comb;
      assign out_valid      = in_valid;
      assign unused_clk_rst = clk ^ rst;
   end

endmodule

// File: tb/tb_mux_2to1_gl.sv
// Self-checking bench for mux_2to1_gl: registered 1-bit and 8-bit builds
// plus an unclocked combinational build.
module tb_mux_2to1_gl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic a1, b1, s1, iv1;
   logic y_comb1, y1, ov1;

   logic [7:0] a8, b8, y_comb8, y8;
   logic       s8, iv8, ov8;

   logic       clk_idle = 1'b0;
   logic       rst_idle = 1'b0;
   logic [3:0] a0, b0, y_comb0, y0;
   logic       s0, iv0, ov0;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mux_2to1_gl #(.WIDTH(1), .REGISTERED(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .s(s1), .in_valid(iv1),
      .y_comb(y_comb1), .y(y1), .out_valid(ov1)
   );

   mux_2to1_gl #(.WIDTH(8), .REGISTERED(1'b1)) u_dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .s(s8), .in_valid(iv8),
      .y_comb(y_comb8), .y(y8), .out_valid(ov8)
   );

   mux_2to1_gl #(.WIDTH(4), .REGISTERED(1'b0)) u_dut0 (
      .clk(clk_idle), .rst(rst_idle), .a(a0), .b(b0), .s(s0), .in_valid(iv0),
      .y_comb(y_comb0), .y(y0), .out_valid(ov0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic s;
      logic a;
      logic b;
      logic exp;
   } tt_vec_t;

   tt_vec_t tt[7];

   logic [7:0] m_y;
   logic       m_ov;
   logic [7:0] sel;
   logic       r;

   initial begin
      tt[0] = '{s:1'b0, a:1'b0, b:1'b0, exp:1'b0};
      tt[1] = '{s:1'b0, a:1'b0, b:1'b1, exp:1'b0};
      tt[2] = '{s:1'b1, a:1'b1, b:1'b0, exp:1'b0};
      tt[3] = '{s:1'b0, a:1'b1, b:1'b1, exp:1'b1};
      tt[4] = '{s:1'b1, a:1'b0, b:1'b1, exp:1'b1};
      tt[5] = '{s:1'b1, a:1'b1, b:1'b1, exp:1'b1};
      tt[6] = '{s:1'b0, a:1'b0, b:1'b0, exp:1'b0};

      a1 = 1'b1; b1 = 1'b1; s1 = 1'b1; iv1 = 1'b1;
      a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; iv8 = 1'b0;
      a0 = 4'h0; b0 = 4'h0; s0 = 1'b0; iv0 = 1'b0;

      // reset state with all-ones inputs on the 1-bit build
      #1;
      chk("rst_y", y1, 0);
      chk("rst_ov", ov1, 0);
      chk("rst_ycomb", y_comb1, 1);
      @(posedge clk); #1;
      chk("rst_hold_y", y1, 0);
      chk("rst_hold_ov", ov1, 0);
      @(negedge clk);
      rst = 1'b0;

      // truth table
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         s1 = tt[i].s; a1 = tt[i].a; b1 = tt[i].b; iv1 = 1'b1;
         #1;
         chk($sformatf("tt%0d_ycomb", i), y_comb1, tt[i].exp);
         @(posedge clk); #1;
         chk($sformatf("tt%0d_y", i), y1, tt[i].exp);
         chk($sformatf("tt%0d_ov", i), ov1, 1);
      end

      // hold
      @(negedge clk);
      a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b1; iv8 = 1'b1;
      @(posedge clk); #1;
      chk("hold_cap_y", y8, 8'h3C);
      chk("hold_cap_ov", ov8, 1);
      @(negedge clk);
      iv8 = 1'b0; s8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d_y", i), y8, 8'h3C);
         chk($sformatf("hold%0d_ov", i), ov8, 0);
         chk($sformatf("hold%0d_ycomb", i), y_comb8, 8'hA5);
      end

      // streaming, s toggling every edge
      a8 = 8'h11; b8 = 8'h22;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s8 = i[0]; iv8 = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("stream%0d_y", i), y8, i[0] ? 8'h22 : 8'h11);
         chk($sformatf("stream%0d_ov", i), ov8, 1);
      end

      // asynchronous reset between edges while out_valid is high
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_y", y8, 0);
      chk("midrst_ov", ov8, 0);
      #1;
      rst = 1'b0;
      a8 = 8'h5A; b8 = 8'hC3; s8 = 1'b0; iv8 = 1'b1;
      #1;
      chk("midrst_still_y", y8, 0);
      @(posedge clk); #1;
      chk("postrst_y", y8, 8'h5A);
      chk("postrst_ov", ov8, 1);

      // randomized traffic against a transaction-level model
      m_y = 8'h5A; m_ov = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom);
         s8 = 1'($urandom); iv8 = 1'($urandom);
         r = ($urandom_range(0, 15) == 0);
         sel = s8 ? b8 : a8;
         rst = r;
         #1;
         chk("rnd_ycomb", y_comb8, sel);
         if (r) begin
            m_y = 8'h00; m_ov = 1'b0;
            chk("rnd_rst_y", y8, 0);
            chk("rnd_rst_ov", ov8, 0);
         end
         #1;
         rst = 1'b0;
         @(posedge clk); #1;
         if (iv8) m_y = sel;
         m_ov = iv8;
         chk("rnd_y", y8, m_y);
         chk("rnd_ov", ov8, m_ov);
      end

      // combinational build, no clock on its port
      for (int i = 0; i < 8; i++) begin
         a0 = 4'($urandom); b0 = 4'($urandom);
         s0 = i[0]; iv0 = i[1];
         #1;
         chk($sformatf("comb%0d_y", i), y0, s0 ? b0 : a0);
         chk($sformatf("comb%0d_ycomb", i), y_comb0, s0 ? b0 : a0);
         chk($sformatf("comb%0d_ov", i), ov0, iv0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
